// File: rtl/flash_image_loader.sv
// rtl/flash_image_loader.sv - boot-time SPI flash reader that copies one image into SRAM
// Optional FLASH_WAKE_EN: send release-power-down (8'hAB) and wait 64 cycles before the read command.
module flash_image_loader #(
    parameter int          CLK_DIV     = 2,
    parameter int          IMAGE_BYTES = 65536,
    parameter logic [23:0] FLASH_BASE  = 24'h100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  configuration,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_datain,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        read_complete
);
    typedef enum logic [2:0] {
        LATCH, WAKE, WAKE_WAIT, CMD, DATA, WRITE, FINISH, DONE
    } state_t;

    localparam logic [7:0] READ_CMD = 8'h03;

    state_t       state;
    state_t       next_state;
    logic [7:0]   div_cnt;
    logic [4:0]   bit_cnt;
    logic [31:0]  tx_shift;
    logic [7:0]   rx_shift;
    logic [16:0]  byte_cnt;
    logic         tick;
    logic         rise;
    logic         fall;
    logic         shifting;
    logic [23:0]  image_addr;
    logic [31:0]  read_cmd;

`ifdef FLASH_WAKE_EN
    localparam logic [7:0] WAKE_CMD = 8'hAB;
    logic [23:0]  flash_addr;
    logic [5:0]   wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_addr <= 24'h0;
            wait_cnt   <= 6'd0;
        end else begin
            if (state == LATCH) begin
                flash_addr <= image_addr;
            end
            wait_cnt <= (state == WAKE_WAIT) ? wait_cnt + 6'd1 : 6'd0;
        end
    end

    assign read_cmd = {READ_CMD, flash_addr};
`else
    assign read_cmd = {READ_CMD, image_addr};
`endif

    // Image base wraps at 24 bits; only used on the LATCH edge.
    assign image_addr = FLASH_BASE + 24'(configuration) * 24'(IMAGE_BYTES);

    assign tick     = (div_cnt == 8'(CLK_DIV - 1));
    assign rise     = tick && !spi_clk;
    assign fall     = tick && spi_clk;
    assign shifting = (state == WAKE) || (state == CMD) || (state == DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LATCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LATCH: begin
`ifdef FLASH_WAKE_EN
                next_state = WAKE;
`else
                next_state = CMD;
`endif
            end
`ifdef FLASH_WAKE_EN
            WAKE: begin
                if (fall && bit_cnt == 5'd7) next_state = WAKE_WAIT;
            end
            WAKE_WAIT: begin
                if (wait_cnt == 6'd63) next_state = CMD;
            end
`endif
            CMD: begin
                if (fall && bit_cnt == 5'd31) next_state = DATA;
            end
            DATA: begin
                if (fall && bit_cnt == 5'd7) next_state = WRITE;
            end
            WRITE: begin
                next_state = (byte_cnt == 17'(IMAGE_BYTES - 1)) ? FINISH : DATA;
            end
            FINISH:  next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = LATCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_clk       <= 1'b0;
            spi_mosi      <= 1'b0;
            spi_cs        <= 1'b1;
            ram_address   <= 16'h0;
            ram_datain    <= 8'h0;
            ram_cs        <= 1'b0;
            ram_we        <= 1'b0;
            read_complete <= 1'b0;
            div_cnt       <= 8'd0;
            bit_cnt       <= 5'd0;
            tx_shift      <= 32'h0;
            rx_shift      <= 8'h0;
            byte_cnt      <= 17'd0;
        end else begin
            ram_cs <= 1'b0;
            ram_we <= 1'b0;

            // Serial engine: mosi moves on falling edges, miso is taken on rising edges.
            if (shifting && next_state == state) begin
                if (tick) begin
                    div_cnt <= 8'd0;
                    spi_clk <= ~spi_clk;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (rise) begin
                    rx_shift <= {rx_shift[6:0], spi_miso};
                end
                if (fall) begin
                    bit_cnt  <= bit_cnt + 5'd1;
                    spi_mosi <= tx_shift[31];
                    tx_shift <= {tx_shift[30:0], 1'b0};
                end
            end

            if (state == WRITE && next_state == DATA) begin
                byte_cnt <= byte_cnt + 17'd1;
            end

            // Entry actions; the first bit of a shifted word is presented on entry.
            if (next_state != state) begin
                div_cnt <= 8'd0;
                bit_cnt <= 5'd0;
                spi_clk <= 1'b0;
                case (next_state)
`ifdef FLASH_WAKE_EN
                    WAKE: begin
                        spi_cs   <= 1'b0;
                        spi_mosi <= WAKE_CMD[7];
                        tx_shift <= {WAKE_CMD[6:0], 25'h0};
                    end
                    WAKE_WAIT: begin
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                    end
`endif
                    CMD: begin
                        spi_cs   <= 1'b0;
                        spi_mosi <= read_cmd[31];
                        tx_shift <= {read_cmd[30:0], 1'b0};
                    end
                    DATA: begin
                        spi_mosi <= 1'b0;
                        tx_shift <= 32'h0;
                    end
                    WRITE: begin
                        ram_cs      <= 1'b1;
                        ram_we      <= 1'b1;
                        ram_address <= byte_cnt[15:0];
                        ram_datain  <= rx_shift;
                    end
                    FINISH: begin
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                    end
                    DONE: begin
                        read_complete <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
